// File: rtl/demux_1xn_deser.sv
// Time-division 1-to-N demultiplexer/deserializer: scatters a framed serial
// stream LSB-first into an N = 2**power_n bit registered parallel word.
module demux_1xn_deser #(
    parameter int power_n = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d,
    input  logic                  d_valid,
    input  logic                  sof,
    output logic [2**power_n-1:0] y,
    output logic                  y_valid,
    output logic                  busy,
    output logic [power_n-1:0]    sel,
    output logic                  resync_err
);

    localparam int N = 2**power_n;
    localparam logic [power_n-1:0] LAST_LANE = {power_n{1'b1}};
    localparam logic [power_n-1:0] LANE_ONE  = power_n'(1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t             state, state_nxt;
    logic [N-1:0]       stage_buf, stage_buf_nxt;
    logic [power_n-1:0] sel_nxt;
    logic [N-1:0]       y_nxt;
    logic               y_valid_nxt;
    logic               resync_err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            stage_buf  <= '0;
            sel        <= '0;
            y          <= '0;
            y_valid    <= 1'b0;
            resync_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            stage_buf  <= stage_buf_nxt;
            sel        <= sel_nxt;
            y          <= y_nxt;
            y_valid    <= y_valid_nxt;
            resync_err <= resync_err_nxt;
        end
    end

    // The completing beat is merged straight into y so the word lands on the
    // same edge that samples lane N-1; every lane is rewritten per frame, so
    // stale bits from an aborted frame can never leak into y.
    always_comb begin
        state_nxt      = state;
        stage_buf_nxt  = stage_buf;
        sel_nxt        = sel;
        y_nxt          = y;
        y_valid_nxt    = 1'b0;
        resync_err_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (d_valid && sof) begin
                    stage_buf_nxt[0] = d;
                    sel_nxt          = LANE_ONE;
                    state_nxt        = COLLECT;
                end
            end
            COLLECT: begin
                if (d_valid) begin
                    if (sof) begin
                        resync_err_nxt   = 1'b1;
                        stage_buf_nxt[0] = d;
                        sel_nxt          = LANE_ONE;
                    end else begin
                        stage_buf_nxt[sel] = d;
                        if (sel == LAST_LANE) begin
                            y_nxt       = {d, stage_buf[N-2:0]};
                            y_valid_nxt = 1'b1;
                            sel_nxt     = '0;
                            state_nxt   = IDLE;
                        end else begin
                            sel_nxt = sel + LANE_ONE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == COLLECT);

endmodule

// File: tb/tb_demux_1xn_deser.sv
// Self-checking bench for demux_1xn_deser: directed frames plus random traffic,
// compared each cycle against a queue-based frame model.
module tb_demux_1xn_deser;

    localparam int POWER_N = 3;
    localparam int N = 2**POWER_N;

    logic               clk = 1'b0;
    logic               rst;
    logic               d;
    logic               d_valid;
    logic               sof;
    logic [N-1:0]       y;
    logic               y_valid;
    logic               busy;
    logic [POWER_N-1:0] sel;
    logic               resync_err;

    int n_compared   = 0;
    int n_mismatched = 0;
    int valid_pulses = 0;
    int resync_pulses = 0;

    // Reference model: bits of the frame in progress, in arrival order.
    bit           in_frame = 0;
    bit           frame_q[$];
    logic [N-1:0] ref_y = '0;
    bit           ref_yv = 0;
    bit           ref_rr = 0;

    demux_1xn_deser #(.power_n(POWER_N)) dut (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .sof(sof),
        .y(y), .y_valid(y_valid), .busy(busy), .sel(sel), .resync_err(resync_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit dv, input bit s, input bit dd);
        if (r) begin
            in_frame = 0;
            frame_q.delete();
            ref_y  = '0;
            ref_yv = 0;
            ref_rr = 0;
        end else begin
            ref_yv = 0;
            ref_rr = 0;
            if (dv) begin
                if (s) begin
                    ref_rr = in_frame;
                    frame_q.delete();
                    frame_q.push_back(dd);
                    in_frame = 1;
                end else if (in_frame) begin
                    frame_q.push_back(dd);
                    if (frame_q.size() == N) begin
                        ref_y = '0;
                        foreach (frame_q[k]) ref_y[k] = frame_q[k];
                        ref_yv = 1;
                        in_frame = 0;
                        frame_q.delete();
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit dv, input bit s, input bit dd);
        int exp_sel;
        rst = r; d_valid = dv; sof = s; d = dd;
        @(posedge clk);
        model_step(r, dv, s, dd);
        #1;
        exp_sel = in_frame ? frame_q.size() : 0;
        checkOutput("y", 64'(y), 64'(ref_y));
        checkOutput("y_valid", 64'(y_valid), 64'(ref_yv));
        checkOutput("resync_err", 64'(resync_err), 64'(ref_rr));
        checkOutput("busy", 64'(busy), 64'(in_frame));
        checkOutput("sel", 64'(sel), 64'(exp_sel));
        if (y_valid === 1'b1) valid_pulses++;
        if (resync_err === 1'b1) resync_pulses++;
    endtask

    task automatic send_frame(input logic [N-1:0] word, input int gap_after, input int gap_len);
        for (int k = 0; k < N; k++) begin
            applyStimulus(0, 1, k == 0, word[k]);
            if (k == gap_after)
                for (int g = 0; g < gap_len; g++) applyStimulus(0, 0, $urandom_range(0, 1), $urandom_range(0, 1));
        end
    endtask

    initial begin
        rst = 1'b1; d = 1'b0; d_valid = 1'b0; sof = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            applyStimulus(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        checkOutput("reset_y", 64'(y), 64'h0);
        checkOutput("reset_sel", 64'(sel), 64'h0);
        applyStimulus(0, 0, 0, 0);

        // Single frame 0x4D
        valid_pulses = 0;
        send_frame(8'h4D, -1, 0);
        checkOutput("single_y", 64'(y), 64'h4D);
        applyStimulus(0, 0, 0, 0);
        checkOutput("single_pulses", 64'(valid_pulses), 64'd1);

        // Gapped 0xFF then back-to-back 0x00
        valid_pulses = 0;
        send_frame(8'hFF, 3, 3);
        checkOutput("gapped_y", 64'(y), 64'hFF);
        send_frame(8'h00, -1, 0);
        checkOutput("b2b_y", 64'(y), 64'h00);
        checkOutput("b2b_pulses", 64'(valid_pulses), 64'd2);

        // Resync mid-frame
        valid_pulses = 0; resync_pulses = 0;
        for (int k = 0; k < 5; k++) applyStimulus(0, 1, k == 0, $urandom_range(0, 1));
        send_frame(8'hA4, -1, 0);
        checkOutput("resync_y", 64'(y), 64'hA4);
        checkOutput("resync_pulses", 64'(resync_pulses), 64'd1);
        checkOutput("resync_valid_pulses", 64'(valid_pulses), 64'd1);

        // Idle noise
        for (int k = 0; k < 10; k++) applyStimulus(0, 1, 0, $urandom_range(0, 1));
        checkOutput("noise_y", 64'(y), 64'hA4);
        checkOutput("noise_busy", 64'(busy), 64'h0);

        // Reset mid-frame, then 0x3C
        valid_pulses = 0;
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, k == 0, $urandom_range(0, 1));
        applyStimulus(1, 1, 0, 1);
        checkOutput("midrst_sel", 64'(sel), 64'h0);
        checkOutput("midrst_busy", 64'(busy), 64'h0);
        checkOutput("midrst_y", 64'(y), 64'h0);
        checkOutput("midrst_pulses", 64'(valid_pulses), 64'd0);
        send_frame(8'h3C, -1, 0);
        checkOutput("after_rst_y", 64'(y), 64'h3C);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/demux_1xn_deser.md
# demux_1xn_deser

Time-division 1-to-N demultiplexer and deserializer. It takes a serial bit stream, typically produced by a counter-driven Nx1 mux serializer, and scatters consecutive bits into an N = 2**power_n wide parallel word. Bit k goes to lane k. It sits at the receive end of a serialized bus and rebuilds the parallel word the N:1 select stage sent, framed by a start-of-frame marker.

## Interface
- power_n, default 3: log2 of lane count; N = 2**power_n; legal range 1..6.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- d  input  1  serial data bit.
- d_valid  input  1  d is a valid beat this cycle.
- sof  input  1  start of frame; qualified only when d_valid=1; marks bit for lane 0.
- y  output  N  last completed parallel word, registered.
- y_valid  output  1  one-cycle pulse: y was updated this cycle.
- busy  output  1  frame in progress (state COLLECT).
- sel  output  power_n  lane index the next valid beat will be written to.
- resync_err  output  1  one-cycle pulse: sof arrived mid-frame.

## Operation
- Internal N-bit staging register buf, plus lane counter sel.
- Bit order: first beat of a frame goes to lane 0 (y[0]); the last beat goes to lane N-1 (y[N-1]). LSB first, matching a serializer whose select counts up from 0.
- FSM states: IDLE and COLLECT.
- IDLE:
  - d_valid & sof: buf[0] <= d, sel <= 1, go to COLLECT.
  - d_valid & !sof: beat is discarded; no state change.
  - sof without d_valid: ignored.
- COLLECT, d_valid & !sof:
  - buf[sel] <= d, sel <= sel+1.
  - If sel == N-1: y <= {d, buf[N-2:0]}, y_valid <= 1, sel <= 0, go to IDLE.
- COLLECT, d_valid & sof (resync):
  - Discard the partial frame, set resync_err <= 1.
  - buf[0] <= d, sel <= 1, remain in COLLECT.
  - y is not updated.
- COLLECT, d_valid=0: hold all state; gaps of any length are allowed.
- Back-to-back frames: a sof beat on the cycle right after the last beat is accepted from IDLE with no lost cycle.
- busy = (state == COLLECT).
- sel wraps modulo N. It never exceeds N-1.
- y holds its value between frames and is never cleared except by rst.
- Stale buf bits from an aborted frame never reach y, because every lane is rewritten before completion.

## Timing
- Reset (rst=1 at an edge) takes priority over all inputs. Afterwards: y=0, y_valid=0, busy=0, sel=0, resync_err=0, buf=0, state IDLE.
- Reset asserted mid-frame abandons the frame; no y_valid pulse results.
- Latency: y and y_valid update on the same edge that samples lane N-1, so they are visible one cycle after the last beat is presented.
- y_valid and resync_err are high for exactly one cycle and are never high together.
- Minimum frame time: N cycles. Throughput: one bit per cycle with d_valid held high.
- All outputs come straight from registers; there are no combinational input-to-output paths.

## Test plan
All scenarios use power_n=3.
- Reset check: drive rst for 2 cycles with random d, d_valid, sof. Required: y=0x00, y_valid=0, busy=0, sel=0 throughout and after release.
- Single frame: sof with d=1, then 0,1,1,0,0,1,0, d_valid held high. Required: y=0x4D with a single y_valid pulse one cycle after the 8th beat; busy high for cycles 2–8; sel steps 1..7 then 0.
- Gapped and back-to-back frames:
  - Send frame 0xFF with d_valid deasserted for 3 cycles between beats 4 and 5. Required: y=0xFF.
  - Immediately send frame 0x00 with no idle cycle. Required: two y_valid pulses 8 valid beats apart; y=0xFF, then 0x00.
- Resync mid-frame: send 5 beats of a frame, then sof with d=0 followed by bits forming 0xA4 (lane 0 = 0). Required: resync_err pulse at the sof beat; no y_valid for the aborted frame; y=0xA4 after 8 more beats.
- Idle noise and reset mid-frame:
  - Send 10 d_valid beats with sof=0 in IDLE. Required: no state change; y unchanged.
  - Assert rst after 3 beats of a frame. Required: sel=0, busy=0, y=0, no y_valid.
  - Send a subsequent full frame 0x3C. Required: y=0x3C.
